// File: rtl/sm_debug_ctrl_if.sv
// Command and register-dump streams between a debug host (master)
// and the run-control sequencer (slave).
interface sm_debug_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, dump_ready,
        input  cmd_ready, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, dump_ready,
        output cmd_ready, dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/sm_debug_ctrl.sv
// Run/halt/step sequencer for the single-cycle core: gates the CPU clock
// enable, holds one PC breakpoint, counts retirements and streams a register dump.
module sm_debug_ctrl #(
    parameter bit START_RUN = 1'b0,
    parameter int DUMP_REGS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    sm_debug_ctrl_if.slave bus,
    input  logic [31:0]    pc,
    output logic           cpu_en,
    output logic [4:0]     reg_addr,
    input  logic [31:0]    reg_data,
    output logic           halted,
    output logic           bp_hit,
    output logic [31:0]    instr_cnt
);
    typedef enum logic [2:0] {
        S_HALT, S_RUN, S_STEP, S_DUMP_RD, S_DUMP_OUT
    } state_t;

    localparam logic [2:0] OP_RUN    = 3'd0;
    localparam logic [2:0] OP_HALT   = 3'd1;
    localparam logic [2:0] OP_STEP   = 3'd2;
    localparam logic [2:0] OP_SET_BP = 3'd3;
    localparam logic [2:0] OP_CLR_BP = 3'd4;
    localparam logic [2:0] OP_DUMP   = 3'd5;

    localparam state_t     RST_STATE = START_RUN ? S_RUN : S_HALT;
    localparam logic [4:0] LAST_ADDR = 5'(DUMP_REGS - 1);

    state_t      state_q, state_d;
    logic        bp_en_q, bp_en_d;
    logic [31:0] bp_addr_q, bp_addr_d;
    logic        bp_hit_q, bp_hit_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] step_cnt_q, step_cnt_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        dump_valid_q, dump_valid_d;
    logic [4:0]  dump_addr_q, dump_addr_d;
    logic [31:0] dump_data_q, dump_data_d;
    logic        skip_q, skip_d;

    logic        cmd_rdy;
    logic        cmd_accept;
    logic        bp_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            bp_en_q      <= 1'b0;
            bp_addr_q    <= '0;
            bp_hit_q     <= 1'b0;
            instr_cnt_q  <= '0;
            step_cnt_q   <= '0;
            reg_addr_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            skip_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            bp_en_q      <= bp_en_d;
            bp_addr_q    <= bp_addr_d;
            bp_hit_q     <= bp_hit_d;
            instr_cnt_q  <= instr_cnt_d;
            step_cnt_q   <= step_cnt_d;
            reg_addr_q   <= reg_addr_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            skip_q       <= skip_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bp_en_d      = bp_en_q;
        bp_addr_d    = bp_addr_q;
        bp_hit_d     = bp_hit_q;
        step_cnt_d   = step_cnt_q;
        reg_addr_d   = reg_addr_q;
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        skip_d       = skip_q;

        cmd_rdy    = (state_q == S_HALT) || (state_q == S_RUN);
        cmd_accept = bus.cmd_valid && cmd_rdy;
        // skip suppresses the match for one cycle so a resume from the breakpoint PC retires it
        bp_match   = bp_en_q && (pc == bp_addr_q) && !skip_q;
        cpu_en     = (state_q == S_STEP) || ((state_q == S_RUN) && !bp_match);
        instr_cnt_d = instr_cnt_q + {31'd0, cpu_en};

        case (state_q)
            S_HALT: begin
                if (cmd_accept) begin
                    case (bus.cmd_op)
                        OP_RUN: begin
                            state_d  = S_RUN;
                            skip_d   = 1'b1;
                            bp_hit_d = 1'b0;
                        end
                        OP_STEP: begin
                            if (bus.cmd_arg != 32'd0) begin
                                state_d    = S_STEP;
                                step_cnt_d = bus.cmd_arg;
                                bp_hit_d   = 1'b0;
                            end
                        end
                        OP_SET_BP: begin
                            bp_addr_d = bus.cmd_arg;
                            bp_en_d   = 1'b1;
                        end
                        OP_CLR_BP: bp_en_d = 1'b0;
                        OP_DUMP: begin
                            state_d    = S_DUMP_RD;
                            reg_addr_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                skip_d = 1'b0;
                if (cmd_accept && bus.cmd_op == OP_SET_BP) begin
                    bp_addr_d = bus.cmd_arg;
                    bp_en_d   = 1'b1;
                end
                if (cmd_accept && bus.cmd_op == OP_CLR_BP) begin
                    bp_en_d = 1'b0;
                end
                if (bp_match) begin
                    state_d  = S_HALT;
                    bp_hit_d = 1'b1;
                end else if (cmd_accept && bus.cmd_op == OP_HALT) begin
                    state_d = S_HALT;
                end
            end
            S_STEP: begin
                step_cnt_d = step_cnt_q - 32'd1;
                if (step_cnt_q == 32'd1) state_d = S_HALT;
            end
            S_DUMP_RD: begin
                dump_data_d  = reg_data;
                dump_addr_d  = reg_addr_q;
                dump_valid_d = 1'b1;
                state_d      = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (bus.dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (dump_addr_q == LAST_ADDR) begin
                        state_d    = S_HALT;
                        reg_addr_d = '0;
                    end else begin
                        reg_addr_d = reg_addr_q + 5'd1;
                        state_d    = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    assign bus.cmd_ready  = cmd_rdy;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign reg_addr       = reg_addr_q;
    assign halted         = (state_q == S_HALT);
    assign bp_hit         = bp_hit_q;
    assign instr_cnt      = instr_cnt_q;
endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Directed bench for sm_debug_ctrl with a pc+4 CPU model and a fixed register file.
module tb_sm_debug_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic        cpu_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        halted;
    logic        bp_hit;
    logic [31:0] instr_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sm_debug_ctrl_if dbg_if();

    sm_debug_ctrl #(.START_RUN(1'b0), .DUMP_REGS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (dbg_if),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .instr_cnt (instr_cnt)
    );

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (32'hDEAD_0000 | {27'd0, a} | ({27'd0, a} << 8));
    endfunction

    assign reg_data = rf_val(reg_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dbg_if.cmd_valid  = 1'b0;
        dbg_if.cmd_op     = 3'd0;
        dbg_if.cmd_arg    = 32'd0;
        dbg_if.dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
        dbg_if.cmd_valid = 1'b1;
        dbg_if.cmd_op    = op;
        dbg_if.cmd_arg   = arg;
        tick();
        dbg_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (halted !== 1'b1) begin nerr++; $display("FAIL reset_halted got %b want 1", halted); end
        nvec++; if (cpu_en !== 1'b0) begin nerr++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
        nvec++; if (instr_cnt !== 32'd0) begin nerr++; $display("FAIL reset_instr_cnt got %0d want 0", instr_cnt); end
        nvec++; if (bp_hit !== 1'b0) begin nerr++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
        nvec++; if (dbg_if.cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_cmd_ready got %b want 1", dbg_if.cmd_ready); end
        nvec++; if ({dbg_if.dump_valid, dbg_if.dump_addr, dbg_if.dump_data, reg_addr} !== 43'd0) begin
            nerr++; $display("FAIL reset_dump got v=%b a=%0d d=%h ra=%0d want zeros",
                             dbg_if.dump_valid, dbg_if.dump_addr, dbg_if.dump_data, reg_addr);
        end
        repeat (10) tick();
        nvec++; if (pc !== 32'd0 || instr_cnt !== 32'd0) begin
            nerr++; $display("FAIL reset_frozen got pc=%h cnt=%0d want 0/0", pc, instr_cnt);
        end
        send_cmd(3'd6, 32'h1234);
        send_cmd(3'd1, 32'd0);
        nvec++; if (halted !== 1'b1 || pc !== 32'd0) begin
            nerr++; $display("FAIL reserved_op got halted=%b pc=%h want 1/0", halted, pc);
        end
    endtask

    task automatic test_step();
        do_reset();
        send_cmd(3'd2, 32'd0);
        nvec++; if (halted !== 1'b1 || instr_cnt !== 32'd0) begin
            nerr++; $display("FAIL step0_noop got halted=%b cnt=%0d want 1/0", halted, instr_cnt);
        end
        send_cmd(3'd2, 32'd3);
        for (int i = 0; i < 5; i++) begin
            nvec++; if (cpu_en !== (i < 3)) begin
                nerr++; $display("FAIL step3_cpu_en cyc%0d got %b want %b", i, cpu_en, (i < 3));
            end
            nvec++; if (dbg_if.cmd_ready !== (i >= 3) || halted !== (i >= 3)) begin
                nerr++; $display("FAIL step3_ready cyc%0d got rdy=%b halted=%b want %b", i,
                                 dbg_if.cmd_ready, halted, (i >= 3));
            end
            tick();
        end
        nvec++; if (instr_cnt !== 32'd3 || pc !== 32'd12) begin
            nerr++; $display("FAIL step3_count got cnt=%0d pc=%h want 3/0c", instr_cnt, pc);
        end
    endtask

    task automatic test_breakpoint();
        do_reset();
        send_cmd(3'd3, 32'h10);
        send_cmd(3'd0, 32'd0);
        for (int i = 0; i < 20 && !halted; i++) tick();
        nvec++; if (halted !== 1'b1 || pc !== 32'h10 || bp_hit !== 1'b1 || instr_cnt !== 32'd4) begin
            nerr++; $display("FAIL bp_stop got halted=%b pc=%h hit=%b cnt=%0d want 1/10/1/4",
                             halted, pc, bp_hit, instr_cnt);
        end
        repeat (3) tick();
        nvec++; if (pc !== 32'h10) begin nerr++; $display("FAIL bp_hold got pc=%h want 10", pc); end
        send_cmd(3'd0, 32'd0);
        nvec++; if (bp_hit !== 1'b0 || cpu_en !== 1'b1) begin
            nerr++; $display("FAIL bp_resume got hit=%b cpu_en=%b want 0/1", bp_hit, cpu_en);
        end
        repeat (2) tick();
        nvec++; if (pc !== 32'h18 || halted !== 1'b0) begin
            nerr++; $display("FAIL bp_past got pc=%h halted=%b want 18/0", pc, halted);
        end
        send_cmd(3'd1, 32'd0);
        nvec++; if (halted !== 1'b1 || instr_cnt !== 32'd7 || pc !== 32'h1c) begin
            nerr++; $display("FAIL bp_halt2 got halted=%b cnt=%0d pc=%h want 1/7/1c", halted, instr_cnt, pc);
        end
    endtask

    task automatic test_halt_cmd();
        do_reset();
        send_cmd(3'd0, 32'd0);
        repeat (4) tick();
        send_cmd(3'd1, 32'd0);
        nvec++; if (halted !== 1'b1 || instr_cnt !== 32'd5 || pc !== 32'd20) begin
            nerr++; $display("FAIL halt_cmd got halted=%b cnt=%0d pc=%0d want 1/5/20", halted, instr_cnt, pc);
        end
        repeat (3) tick();
        nvec++; if (instr_cnt !== 32'd5) begin nerr++; $display("FAIL halt_hold got cnt=%0d want 5", instr_cnt); end

        do_reset();
        send_cmd(3'd3, 32'h8);
        send_cmd(3'd0, 32'd0);
        repeat (2) tick();
        nvec++; if (pc !== 32'h8 || cpu_en !== 1'b0) begin
            nerr++; $display("FAIL halt_bp_match got pc=%h cpu_en=%b want 8/0", pc, cpu_en);
        end
        send_cmd(3'd1, 32'd0);
        nvec++; if (halted !== 1'b1 || bp_hit !== 1'b1 || instr_cnt !== 32'd2 || pc !== 32'h8) begin
            nerr++; $display("FAIL halt_bp_coincide got halted=%b hit=%b cnt=%0d pc=%h want 1/1/2/8",
                             halted, bp_hit, instr_cnt, pc);
        end
    endtask

    task automatic test_bp_in_run();
        do_reset();
        send_cmd(3'd0, 32'd0);
        send_cmd(3'd3, 32'hC);
        for (int i = 0; i < 20 && !halted; i++) tick();
        nvec++; if (halted !== 1'b1 || pc !== 32'hC || bp_hit !== 1'b1 || instr_cnt !== 32'd3) begin
            nerr++; $display("FAIL bp_set_in_run got halted=%b pc=%h hit=%b cnt=%0d want 1/c/1/3",
                             halted, pc, bp_hit, instr_cnt);
        end
    endtask

    task automatic test_dump();
        int          idx = 0;
        logic        prev_v = 1'b0, prev_r = 1'b0;
        logic [31:0] prev_d = 32'd0;
        logic [4:0]  prev_a = 5'd0;
        int          cpu_bad = 0;
        do_reset();
        send_cmd(3'd5, 32'd0);
        for (int cyc = 0; cyc < 400 && idx < 32; cyc++) begin
            dbg_if.dump_ready = 1'($urandom_range(0, 1));
            #1;
            if (cpu_en !== 1'b0) cpu_bad++;
            if (prev_v && !prev_r) begin
                nvec++; if (dbg_if.dump_valid !== 1'b1 || dbg_if.dump_data !== prev_d || dbg_if.dump_addr !== prev_a) begin
                    nerr++; $display("FAIL dump_stable got v=%b a=%0d d=%h want 1/%0d/%h",
                                     dbg_if.dump_valid, dbg_if.dump_addr, dbg_if.dump_data, prev_a, prev_d);
                end
            end
            if (dbg_if.dump_valid === 1'b1 && dbg_if.dump_ready) begin
                nvec++; if (dbg_if.dump_addr !== 5'(idx) || dbg_if.dump_data !== rf_val(5'(idx))) begin
                    nerr++; $display("FAIL dump_word got a=%0d d=%h want %0d/%h",
                                     dbg_if.dump_addr, dbg_if.dump_data, idx, rf_val(5'(idx)));
                end
                idx++;
            end
            prev_v = dbg_if.dump_valid;
            prev_r = dbg_if.dump_ready;
            prev_d = dbg_if.dump_data;
            prev_a = dbg_if.dump_addr;
            tick();
        end
        dbg_if.dump_ready = 1'b0;
        nvec++; if (idx != 32) begin nerr++; $display("FAIL dump_count got %0d want 32", idx); end
        nvec++; if (cpu_bad != 0) begin nerr++; $display("FAIL dump_cpu_frozen got %0d enabled cycles want 0", cpu_bad); end
        nvec++; if (halted !== 1'b1 || dbg_if.dump_valid !== 1'b0 || reg_addr !== 5'd0) begin
            nerr++; $display("FAIL dump_end got halted=%b v=%b ra=%0d want 1/0/0", halted, dbg_if.dump_valid, reg_addr);
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        do_reset();
        send_cmd(3'd5, 32'd0);
        dbg_if.dump_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (dbg_if.dump_valid === 1'b1 && dbg_if.dump_addr == 5'd7) break;
            tick();
        end
        dbg_if.dump_ready = 1'b0;
        nvec++; if (dbg_if.dump_valid !== 1'b1 || dbg_if.dump_addr !== 5'd7) begin
            nerr++; $display("FAIL abort_dump_reach got v=%b a=%0d want 1/7", dbg_if.dump_valid, dbg_if.dump_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({dbg_if.dump_valid, dbg_if.dump_addr, dbg_if.dump_data, reg_addr} !== 43'd0 || halted !== 1'b1) begin
            nerr++; $display("FAIL abort_dump_reset got v=%b a=%0d d=%h ra=%0d halted=%b want zeros/1",
                             dbg_if.dump_valid, dbg_if.dump_addr, dbg_if.dump_data, reg_addr, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dbg_if.dump_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dbg_if.dump_valid !== 1'b0 || halted !== 1'b1) seen++;
        end
        dbg_if.dump_ready = 1'b0;
        nvec++; if (seen != 0) begin nerr++; $display("FAIL abort_dump_resume got %0d bad cycles want 0", seen); end

        send_cmd(3'd2, 32'd1000);
        repeat (900) tick();
        nvec++; if (cpu_en !== 1'b1 || instr_cnt !== 32'd900) begin
            nerr++; $display("FAIL abort_step_mid got cpu_en=%b cnt=%0d want 1/900", cpu_en, instr_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (cpu_en !== 1'b0 || instr_cnt !== 32'd0 || halted !== 1'b1 || dbg_if.cmd_ready !== 1'b1 || pc !== 32'd0) begin
            nerr++; $display("FAIL abort_step_reset got cpu_en=%b cnt=%0d halted=%b rdy=%b pc=%h want 0/0/1/1/0",
                             cpu_en, instr_cnt, halted, dbg_if.cmd_ready, pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_en !== 1'b0) seen++;
        end
        nvec++; if (seen != 0 || pc !== 32'd0) begin
            nerr++; $display("FAIL abort_step_resume got %0d enabled cycles pc=%h want 0/0", seen, pc);
        end
    endtask

    task automatic test_step_max();
        int off = 0;
        do_reset();
        send_cmd(3'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 50; i++) begin
            if (cpu_en !== 1'b1 || dbg_if.cmd_ready !== 1'b0) off++;
            tick();
        end
        nvec++; if (off != 0 || instr_cnt !== 32'd50) begin
            nerr++; $display("FAIL step_max got %0d off cycles cnt=%0d want 0/50", off, instr_cnt);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_step();
        test_breakpoint();
        test_halt_cmd();
        test_bp_in_run();
        test_dump();
        test_reset_abort();
        test_step_max();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
